instr_ctrl: RTL

- Instruction decode and sequencing unit for the PIC16F core; the upstream driver of the ALU.
- Latches each 14-bit instruction from program memory and runs the 4-phase Q1..Q4 instruction cycle.
- Drives the ALU op, destination, status-enable, bit-index and operand-select controls.
- Issues regfile, W, PC and stack strobes, and handles skips and two-cycle flushes.

---
 rtl/instr_ctrl_if.sv | 40 ++++
 rtl/instr_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_ctrl_if.sv
// Bus between the PIC16F instruction controller and the ALU, regfile, W, PC and stack.
// The master side is instr_ctrl.
interface instr_ctrl_if #(
    parameter int PC_WIDTH = 11
);
    logic [13:0]         instr;
    logic [7:0]          alu_out;
    logic                alu_bit_test_res;
    logic [3:0]          alu_op;
    logic                alu_d;
    logic                alu_status_wr_en;
    logic [2:0]          alu_b_in;
    logic                lit_sel;
    logic [7:0]          literal;
    logic [6:0]          f_addr;
    logic                f_wr_en;
    logic                w_wr_en;
    logic                pc_inc;
    logic                pc_load;
    logic                pc_src;
    logic [PC_WIDTH-1:0] pc_load_addr;
    logic                stack_push;
    logic                stack_pop;
    logic                flushing;
    logic                illegal_instr;

    modport master (
        input  instr, alu_out, alu_bit_test_res,
        output alu_op, alu_d, alu_status_wr_en, alu_b_in, lit_sel, literal, f_addr,
               f_wr_en, w_wr_en, pc_inc, pc_load, pc_src, pc_load_addr,
               stack_push, stack_pop, flushing, illegal_instr
    );

    modport slave (
        output instr, alu_out, alu_bit_test_res,
        input  alu_op, alu_d, alu_status_wr_en, alu_b_in, lit_sel, literal, f_addr,
               f_wr_en, w_wr_en, pc_inc, pc_load, pc_src, pc_load_addr,
               stack_push, stack_pop, flushing, illegal_instr
    );
endinterface

// File: rtl/instr_ctrl.sv
// PIC16F instruction decode and Q1..Q4 sequencer: latches IR, registers decode at end of Q1,
// pulses write/PC/stack strobes in Q4 and flushes the cycle after a taken skip or branch.
module instr_ctrl #(
    parameter int PC_WIDTH = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_ctrl_if.master  bus
);

    localparam logic [3:0] alu_op_add    = 4'h0;
    localparam logic [3:0] alu_op_sub    = 4'h1;
    localparam logic [3:0] alu_op_and    = 4'h2;
    localparam logic [3:0] alu_op_or     = 4'h3;
    localparam logic [3:0] alu_op_xor    = 4'h4;
    localparam logic [3:0] alu_op_com    = 4'h5;
    localparam logic [3:0] alu_op_dec    = 4'h6;
    localparam logic [3:0] alu_op_inc    = 4'h7;
    localparam logic [3:0] alu_op_passlf = 4'h8;
    localparam logic [3:0] alu_op_rl     = 4'h9;
    localparam logic [3:0] alu_op_rr     = 4'hA;
    localparam logic [3:0] alu_op_swap   = 4'hB;
    localparam logic [3:0] alu_op_zero   = 4'hC;
    localparam logic [3:0] alu_op_passw  = 4'hD;
    localparam logic [3:0] alu_op_bc     = 4'hE;
    localparam logic [3:0] alu_op_bs     = 4'hF;

    typedef enum logic [1:0] {PH_Q1 = 2'd0, PH_Q2 = 2'd1, PH_Q3 = 2'd2, PH_Q4 = 2'd3} phase_t;

    phase_t      phase_r;
    logic [13:0] ir_r;
    logic        flushing_r;
    logic [3:0]  alu_op_r;
    logic        alu_d_r, status_r, lit_sel_r, pc_src_r;
    logic [2:0]  b_in_r;
    logic        wr_r, branch_r, push_r, pop_r, skip_z_r, skip_b_r, illegal_r;
    logic        f_wr_en_r, w_wr_en_r, pc_inc_r, pc_load_r;
    logic        stack_push_r, stack_pop_r, illegal_instr_r;

    logic [3:0]  dec_op_s;
    logic        dec_d_s, dec_status_s, dec_lit_s, dec_src_s;
    logic        dec_wr_s, dec_branch_s, dec_push_s, dec_pop_s;
    logic        dec_skip_z_s, dec_skip_b_s, dec_illegal_s;

    // Combinational opcode decode of the instruction register.
    always_comb begin
        dec_op_s      = alu_op_add;
        dec_d_s       = 1'b0;
        dec_status_s  = 1'b0;
        dec_lit_s     = 1'b0;
        dec_src_s     = 1'b0;
        dec_wr_s      = 1'b0;
        dec_branch_s  = 1'b0;
        dec_push_s    = 1'b0;
        dec_pop_s     = 1'b0;
        dec_skip_z_s  = 1'b0;
        dec_skip_b_s  = 1'b0;
        dec_illegal_s = 1'b0;
        case (ir_r[13:12])
            2'b00: begin
                if (ir_r[11:8] == 4'h0) begin
                    if (ir_r[7]) begin
                        dec_op_s = alu_op_passw;
                        dec_d_s  = 1'b1;
                        dec_wr_s = 1'b1;
                    end else if (ir_r == 14'h0008) begin
                        dec_branch_s = 1'b1;
                        dec_src_s    = 1'b1;
                        dec_pop_s    = 1'b1;
                    end else if (ir_r[4:0] == 5'd0) begin
                        dec_op_s = alu_op_add;
                    end else begin
                        dec_illegal_s = 1'b1;
                    end
                end else begin
                    // Byte-oriented file ops: destination from d bit, status on by default.
                    dec_wr_s     = 1'b1;
                    dec_d_s      = ir_r[7];
                    dec_status_s = 1'b1;
                end
                case (ir_r[11:8])
                    4'h0: dec_wr_s = dec_wr_s;
                    4'h1: dec_op_s = alu_op_zero;
                    4'h2: dec_op_s = alu_op_sub;
                    4'h3: dec_op_s = alu_op_dec;
                    4'h4: dec_op_s = alu_op_or;
                    4'h5: dec_op_s = alu_op_and;
                    4'h6: dec_op_s = alu_op_xor;
                    4'h7: dec_op_s = alu_op_add;
                    4'h8: dec_op_s = alu_op_passlf;
                    4'h9: dec_op_s = alu_op_com;
                    4'hA: dec_op_s = alu_op_inc;
                    4'hB: begin dec_op_s = alu_op_dec; dec_status_s = 1'b0; dec_skip_z_s = 1'b1; end
                    4'hC: dec_op_s = alu_op_rr;
                    4'hD: dec_op_s = alu_op_rl;
                    4'hE: begin dec_op_s = alu_op_swap; dec_status_s = 1'b0; end
                    4'hF: begin dec_op_s = alu_op_inc; dec_status_s = 1'b0; dec_skip_z_s = 1'b1; end
                    default: dec_illegal_s = 1'b1;
                endcase
            end
            2'b01: begin
                case (ir_r[11:10])
                    2'b00: begin dec_op_s = alu_op_bc; dec_d_s = 1'b1; dec_wr_s = 1'b1; end
                    2'b01: begin dec_op_s = alu_op_bs; dec_d_s = 1'b1; dec_wr_s = 1'b1; end
                    2'b10: begin dec_op_s = alu_op_bc; dec_skip_b_s = 1'b1; end
                    2'b11: begin dec_op_s = alu_op_bs; dec_skip_b_s = 1'b1; end
                    default: dec_illegal_s = 1'b1;
                endcase
            end
            2'b10: begin
                dec_branch_s = 1'b1;
                dec_push_s   = ~ir_r[11];
            end
            2'b11: begin
                dec_lit_s = 1'b1;
                dec_wr_s  = 1'b1;
                casez (ir_r[11:8])
                    4'b00??: dec_op_s = alu_op_passlf;
                    4'b01??: begin
                        dec_op_s     = alu_op_passlf;
                        dec_branch_s = 1'b1;
                        dec_src_s    = 1'b1;
                        dec_pop_s    = 1'b1;
                    end
                    4'b1000: begin dec_op_s = alu_op_or;  dec_status_s = 1'b1; end
                    4'b1001: begin dec_op_s = alu_op_and; dec_status_s = 1'b1; end
                    4'b1010: begin dec_op_s = alu_op_xor; dec_status_s = 1'b1; end
                    4'b110?: begin dec_op_s = alu_op_sub; dec_status_s = 1'b1; end
                    4'b111?: begin dec_op_s = alu_op_add; dec_status_s = 1'b1; end
                    default: begin dec_lit_s = 1'b0; dec_wr_s = 1'b0; dec_illegal_s = 1'b1; end
                endcase
            end
            default: dec_illegal_s = 1'b1;
        endcase
    end

    // Phase sequencer, IR/flush latch, decode register and Q4 strobe generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r         <= PH_Q1;
            ir_r            <= 14'h0000;
            flushing_r      <= 1'b1;
            alu_op_r        <= 4'h0;
            alu_d_r         <= 1'b0;
            status_r        <= 1'b0;
            lit_sel_r       <= 1'b0;
            pc_src_r        <= 1'b0;
            b_in_r          <= 3'd0;
            wr_r            <= 1'b0;
            branch_r        <= 1'b0;
            push_r          <= 1'b0;
            pop_r           <= 1'b0;
            skip_z_r        <= 1'b0;
            skip_b_r        <= 1'b0;
            illegal_r       <= 1'b0;
            f_wr_en_r       <= 1'b0;
            w_wr_en_r       <= 1'b0;
            pc_inc_r        <= 1'b0;
            pc_load_r       <= 1'b0;
            stack_push_r    <= 1'b0;
            stack_pop_r     <= 1'b0;
            illegal_instr_r <= 1'b0;
        end else begin
            f_wr_en_r       <= 1'b0;
            w_wr_en_r       <= 1'b0;
            pc_inc_r        <= 1'b0;
            pc_load_r       <= 1'b0;
            stack_push_r    <= 1'b0;
            stack_pop_r     <= 1'b0;
            illegal_instr_r <= 1'b0;
            case (phase_r)
                PH_Q1: begin
                    phase_r <= PH_Q2;
                    // A flushed cycle decodes as a NOP so every skip/branch flag stays clear.
                    if (flushing_r) begin
                        alu_op_r  <= 4'h0;
                        alu_d_r   <= 1'b0;
                        status_r  <= 1'b0;
                        lit_sel_r <= 1'b0;
                        pc_src_r  <= 1'b0;
                        b_in_r    <= 3'd0;
                        wr_r      <= 1'b0;
                        branch_r  <= 1'b0;
                        push_r    <= 1'b0;
                        pop_r     <= 1'b0;
                        skip_z_r  <= 1'b0;
                        skip_b_r  <= 1'b0;
                        illegal_r <= 1'b0;
                    end else begin
                        alu_op_r  <= dec_op_s;
                        alu_d_r   <= dec_d_s;
                        status_r  <= dec_status_s;
                        lit_sel_r <= dec_lit_s;
                        pc_src_r  <= dec_src_s;
                        b_in_r    <= ir_r[9:7];
                        wr_r      <= dec_wr_s;
                        branch_r  <= dec_branch_s;
                        push_r    <= dec_push_s;
                        pop_r     <= dec_pop_s;
                        skip_z_r  <= dec_skip_z_s;
                        skip_b_r  <= dec_skip_b_s;
                        illegal_r <= dec_illegal_s;
                    end
                end
                PH_Q2: phase_r <= PH_Q3;
                PH_Q3: begin
                    phase_r         <= PH_Q4;
                    f_wr_en_r       <= wr_r & alu_d_r;
                    w_wr_en_r       <= wr_r & ~alu_d_r;
                    pc_inc_r        <= ~branch_r;
                    pc_load_r       <= branch_r;
                    stack_push_r    <= push_r;
                    stack_pop_r     <= pop_r;
                    illegal_instr_r <= illegal_r;
                end
                PH_Q4: begin
                    phase_r    <= PH_Q1;
                    ir_r       <= bus.instr;
                    flushing_r <= ~flushing_r & (branch_r
                                  | (skip_z_r & (bus.alu_out == 8'h00))
                                  | (skip_b_r & bus.alu_bit_test_res));
                end
                default: phase_r <= PH_Q1;
            endcase
        end
    end

    assign bus.alu_op           = alu_op_r;
    assign bus.alu_d            = alu_d_r;
    assign bus.alu_status_wr_en = status_r;
    assign bus.alu_b_in         = b_in_r;
    assign bus.lit_sel          = lit_sel_r;
    assign bus.literal          = ir_r[7:0];
    assign bus.f_addr           = ir_r[6:0];
    assign bus.pc_src           = pc_src_r;
    assign bus.pc_load_addr     = ir_r[PC_WIDTH-1:0];
    assign bus.f_wr_en          = f_wr_en_r;
    assign bus.w_wr_en          = w_wr_en_r;
    assign bus.pc_inc           = pc_inc_r;
    assign bus.pc_load          = pc_load_r;
    assign bus.stack_push       = stack_push_r;
    assign bus.stack_pop        = stack_pop_r;
    assign bus.flushing         = flushing_r;
    assign bus.illegal_instr    = illegal_instr_r;

endmodule
